tqvp_edge_counter_mc: RTL and testbench
=======================================

# tqvp_edge_counter_mc

Multi-channel, parametrised edge counter peripheral for the TinyQV peripheral bus. It is the successor of the single-channel 8-bit edge counter. It counts rising, falling or both edges on up to four `ui_in` pins, each through a synchroniser, into counters of configurable width. Each channel has a compare/auto-reload register, sticky match and overflow flags, and a level interrupt; match flags are also driven on `uo_out`.

## Interface
- `NUM_CH`, 4, channel count, 1..4; channel n uses `ui_in[n]`.
- `CNT_WIDTH`, 16, counter and compare width, 8 or 16.
- `SYNC_STAGES`, 2, synchroniser flops per input, 2..3.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ui_in`  in  8  edge inputs; bits ≥ `NUM_CH` are ignored.
- `uo_out`  out  8  bits[NUM_CH-1:0] = match flags; remaining bits are 0.
- `address`  in  4  register address.
- `data_write`  in  1  one-cycle write strobe.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data, combinational from `address`.
- `user_interrupt`  out  1  OR over channels of (match flag AND irq_en).

## Operation
Registers (SEL = selected channel):
- 0x0 CTRL: [1:0] SEL (read/write); values ≥ `NUM_CH` are stored but select nothing, so reads return 0 and writes are ignored. Writing [7]=1 clears SEL's counter (self-clearing, reads 0).
- 0x1 MODE[SEL]: [1:0] edge mode (0 off, 1 rise, 2 fall, 3 both), [2] irq_en, [3] auto_reload.
- 0x2/0x3 CNT_LO/HI: a write loads the live counter byte of SEL; a read returns the snapshot byte.
- 0x4 SNAP: any write copies SEL's live counter into the snapshot register (atomic 16-bit read). Reads 0.
- 0x5/0x6 CMP_LO/HI[SEL]: compare value, read/write.
- 0x7 STATUS: [3:0] match flags, [7:4] overflow flags. Write 1 to clear; write 0 has no effect.
- 0x8–0xF: read 0; writes are ignored.

When `CNT_WIDTH`=8, HI reads return 0 and HI writes are ignored.

Counting:
- Each input passes through `SYNC_STAGES` flops, then an edge detector (compares against a prev flop).
- On a qualifying edge: next = counter+1, modulo 2^CNT_WIDTH.
- If next == CMP:
  - set the match flag;
  - if auto_reload, the counter becomes 0 instead of next.
- If counter was all-ones and the event wraps it: set the overflow flag. Match is still evaluated against 0.
- Mode 0: no counting. Flags hold their value.
- CMP = 0 without auto_reload: match fires on wrap.

Priority per channel, same cycle:
- Counter: CTRL clear > CNT write > edge increment. A losing edge is dropped and sets no flag.
- Flags: a set from an edge in the same cycle beats a STATUS write-1-clear.

Reset (async, `rst_n`=0), all outputs and state:
- Counters, CMP, MODE, SEL, snapshot, flags = 0.
- `uo_out`=0, `user_interrupt`=0.
- Synchroniser and prev flops = 0.

After release, a warm-up counter holds off edge detection for `SYNC_STAGES`+1 cycles; prev tracks the synchroniser output during warm-up. An input held high through reset therefore produces no count.

## Timing
- Input change settled before clk edge k → counter and flags update at edge k+`SYNC_STAGES` (synchroniser) +1 (detect). Default: 3 edges.
- Input level must hold ≥ 1 clk period on each side of an edge to be counted; narrower pulses may be missed.
- Register writes take effect at the clk edge where `data_write`=1.
- `data_out` reflects the new value in the following cycle.
- `user_interrupt` and `uo_out` are registered-flag functions, valid the cycle after the flag sets.
- Reset assertion is immediate and asynchronous. Mid-count reset drops in-flight edges. Release is synchronous to clk through the warm-up counter.
- Throughput: one count per channel per cycle; all channels count independently in the same cycle.

## Test plan
- Reset: hold `ui_in[0]`=1 across reset, SEL=0, MODE=1, wait 10 cycles → SNAP then read CNT_LO=0x00; `uo_out`=0x00, `user_interrupt`=0.
- Latency: MODE[1]=1, CTRL=1. Raise `ui_in[1]` before edge k → counter still 0 at edge k+2 and 1 at edge k+3. Five pulses → SNAP reads LO=0x05, HI=0x00.
- Both-edges and falling mode: channel 2 MODE=3 and channel 3 MODE=2, 4 full pulses on each → 8 and 4 respectively.
- Compare with reload and interrupt: CMP=0x0003, MODE=0x0D. After 3 rising edges → counter=0, STATUS=0x01, `uo_out`[0]=1, `user_interrupt`=1. Write STATUS=0x01 → all clear.
- Wrap: CNT=0xFFFF, MODE=1, one edge → counter 0x0000, STATUS[4]=1. With `CNT_WIDTH`=8: CNT_LO=0xFF → 0x00, HI reads 0.
- Collisions: edge in the same cycle as a CNT_LO=0x40 write → counter 0x40. Match set in the same cycle as STATUS clear → flag remains 1.

Source files
------------

// File: rtl/tqvp_edge_counter_mc.sv
// Multi-channel edge counter for the TinyQV peripheral bus: synchronised inputs,
// per-channel counter with compare/auto-reload, sticky match/overflow flags and interrupt.
module tqvp_edge_counter_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       user_interrupt
);
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    // Replace one byte of a counter-width value; high-byte writes vanish when the width is 8.
    function automatic logic [CNT_WIDTH-1:0] load_byte(input logic [CNT_WIDTH-1:0] cur,
                                                       input logic [7:0] b, input logic hi);
        logic [15:0] t;
        t = 16'(cur);
        if (hi) t[15:8] = b;
        else    t[7:0]  = b;
        return CNT_WIDTH'(t);
    endfunction

    logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_p0;
    logic [NUM_CH-1:0]    prev_p1, rise_p1, fall_p1;
    logic [2:0]           warm;
    logic                 warm_done;

    logic [CNT_WIDTH-1:0] cnt     [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_nxt [NUM_CH];
    logic [CNT_WIDTH-1:0] cmp     [NUM_CH];
    logic [3:0]           mode    [NUM_CH];
    logic [CNT_WIDTH-1:0] snap;
    logic [1:0]           sel;
    logic [NUM_CH-1:0]    match_flg, ovf_flg, match_set, ovf_set, sel_hit, irq_en, evt;

    logic wr_ctrl, wr_mode, wr_cnt_lo, wr_cnt_hi, wr_snap, wr_cmp_lo, wr_cmp_hi, wr_status, clr_req;
    logic unused_ui;

    assign wr_ctrl   = data_write && (address == 4'h0);
    assign wr_mode   = data_write && (address == 4'h1);
    assign wr_cnt_lo = data_write && (address == 4'h2);
    assign wr_cnt_hi = data_write && (address == 4'h3) && (CNT_WIDTH > 8);
    assign wr_snap   = data_write && (address == 4'h4);
    assign wr_cmp_lo = data_write && (address == 4'h5);
    assign wr_cmp_hi = data_write && (address == 4'h6) && (CNT_WIDTH > 8);
    assign wr_status = data_write && (address == 4'h7);
    assign clr_req   = wr_ctrl && data_in[7];
    assign warm_done = (warm == WARM_DONE);
    assign unused_ui = ^ui_in;

    // Stage p0/p1: synchronise, then register the detected edge; detection is held off
    // during warm-up so a level present through reset is not mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            prev_p1 <= '0;
            rise_p1 <= '0;
            fall_p1 <= '0;
            warm    <= '0;
        end else begin
            if (!warm_done) warm <= warm + 3'd1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sync_p0[ch] <= {sync_p0[ch][SYNC_STAGES-2:0], ui_in[ch]};
                prev_p1[ch] <= sync_p0[ch][SYNC_STAGES-1];
                rise_p1[ch] <= warm_done &&  sync_p0[ch][SYNC_STAGES-1] && !prev_p1[ch];
                fall_p1[ch] <= warm_done && !sync_p0[ch][SYNC_STAGES-1] &&  prev_p1[ch];
            end
        end
    end

    // Stage p2: counter next-state; a CTRL clear targets the channel named in the same write.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sel_hit[ch]   = (ch == int'(sel));
            irq_en[ch]    = mode[ch][2];
            evt[ch]       = (mode[ch][0] && rise_p1[ch]) || (mode[ch][1] && fall_p1[ch]);
            cnt_nxt[ch]   = cnt[ch];
            match_set[ch] = 1'b0;
            ovf_set[ch]   = 1'b0;
            if (clr_req && (ch == int'(data_in[1:0]))) begin
                cnt_nxt[ch] = '0;
            end else if (wr_cnt_lo && sel_hit[ch]) begin
                cnt_nxt[ch] = load_byte(cnt[ch], data_in, 1'b0);
            end else if (wr_cnt_hi && sel_hit[ch]) begin
                cnt_nxt[ch] = load_byte(cnt[ch], data_in, 1'b1);
            end else if (evt[ch]) begin
                ovf_set[ch]   = &cnt[ch];
                match_set[ch] = ((cnt[ch] + CNT_WIDTH'(1)) == cmp[ch]);
                cnt_nxt[ch]   = (match_set[ch] && mode[ch][3]) ? '0 : cnt[ch] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch]  <= '0;
                cmp[ch]  <= '0;
                mode[ch] <= '0;
            end
            match_flg <= '0;
            ovf_flg   <= '0;
            sel       <= '0;
            snap      <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch] <= cnt_nxt[ch];
                if (wr_mode && sel_hit[ch])   mode[ch] <= data_in[3:0];
                if (wr_cmp_lo && sel_hit[ch]) cmp[ch]  <= load_byte(cmp[ch], data_in, 1'b0);
                if (wr_cmp_hi && sel_hit[ch]) cmp[ch]  <= load_byte(cmp[ch], data_in, 1'b1);
                if (wr_snap && sel_hit[ch])   snap     <= cnt[ch];
                match_flg[ch] <= (match_flg[ch] && !(wr_status && data_in[ch]))     || match_set[ch];
                ovf_flg[ch]   <= (ovf_flg[ch]   && !(wr_status && data_in[4 + ch])) || ovf_set[ch];
            end
            if (wr_ctrl) sel <= data_in[1:0];
        end
    end

    logic [15:0] sel_cmp, snap16;
    logic [3:0]  sel_mode;

    always_comb begin
        sel_cmp  = '0;
        sel_mode = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sel_hit[ch]) begin
                sel_cmp  = 16'(cmp[ch]);
                sel_mode = mode[ch];
            end
        end
        snap16   = (|sel_hit) ? 16'(snap) : 16'h0000;
        data_out = 8'h00;
        case (address)
            4'h0:    data_out = {6'b0, sel};
            4'h1:    data_out = {4'b0, sel_mode};
            4'h2:    data_out = snap16[7:0];
            4'h3:    data_out = snap16[15:8];
            4'h5:    data_out = sel_cmp[7:0];
            4'h6:    data_out = sel_cmp[15:8];
            4'h7:    data_out = {4'(ovf_flg), 4'(match_flg)};
            default: data_out = 8'h00;
        endcase
    end

    assign uo_out         = 8'(match_flg);
    assign user_interrupt = |(match_flg & irq_en);
endmodule

// File: tb/tb_tqvp_edge_counter_mc.sv
// Bench for tqvp_edge_counter_mc: 16-bit and 8-bit instances driven in parallel and
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_tqvp_edge_counter_mc;
    localparam int S = 2;

    logic       clk = 1'b0, rst_n = 1'b0, data_write = 1'b0;
    logic [7:0] ui_in = 8'h00, data_in = 8'h00;
    logic [3:0] address = 4'h0;
    logic [7:0] uo16, uo8, do16, do8;
    logic       irq16, irq8;

    int checks = 0, errors = 0;
    bit cmp_en = 1'b1;

    tqvp_edge_counter_mc #(.NUM_CH(4), .CNT_WIDTH(16), .SYNC_STAGES(S)) dut16 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16), .address(address),
        .data_write(data_write), .data_in(data_in), .data_out(do16), .user_interrupt(irq16));
    tqvp_edge_counter_mc #(.NUM_CH(4), .CNT_WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo8), .address(address),
        .data_write(data_write), .data_in(data_in), .data_out(do8), .user_interrupt(irq8));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, index 0 = 16-bit instance, 1 = 8-bit instance
    logic [15:0] m_cnt [2][4];
    logic [15:0] m_cmp [2][4];
    logic [3:0]  m_mode[2][4];
    logic [15:0] m_snap[2];
    logic [3:0]  m_match[2], m_ovf[2];
    logic [1:0]  m_sel[2];
    logic [3:0]  hist[S+3];
    int          n_edges;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                m_cnt[i][ch] = 16'h0; m_cmp[i][ch] = 16'h0; m_mode[i][ch] = 4'h0;
            end
            m_snap[i] = 16'h0; m_match[i] = 4'h0; m_ovf[i] = 4'h0; m_sel[i] = 2'd0;
        end
        for (int j = 0; j < S + 3; j++) hist[j] = 4'h0;
        n_edges = 0;
    endtask

    // An input level sampled at edge m is counted at edge m+S+1, compared with the level at m-1.
    task automatic model_step();
        logic [15:0] mask, nxt;
        logic [15:0] old_cnt[4];
        logic        nw, od, ev, gate, set_m, set_o;
        logic [3:0]  md;
        int          s;
        n_edges++;
        for (int j = S + 2; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = ui_in[3:0];
        gate = (n_edges >= S + 3);
        for (int i = 0; i < 2; i++) begin
            mask = (i == 0) ? 16'hFFFF : 16'h00FF;
            s = int'(m_sel[i]);
            for (int ch = 0; ch < 4; ch++) old_cnt[ch] = m_cnt[i][ch];
            if (data_write && address == 4'h4) m_snap[i] = old_cnt[s];
            for (int ch = 0; ch < 4; ch++) begin
                nw = hist[S+1][ch];
                od = hist[S+2][ch];
                md = m_mode[i][ch];
                ev = gate && ((md[0] && nw && !od) || (md[1] && !nw && od));
                set_m = 1'b0;
                set_o = 1'b0;
                if (data_write && address == 4'h0 && data_in[7] && int'(data_in[1:0]) == ch)
                    m_cnt[i][ch] = 16'h0;
                else if (data_write && address == 4'h2 && ch == s)
                    m_cnt[i][ch] = {m_cnt[i][ch][15:8], data_in};
                else if (data_write && address == 4'h3 && i == 0 && ch == s)
                    m_cnt[i][ch] = {data_in, m_cnt[i][ch][7:0]};
                else if (ev) begin
                    nxt = (old_cnt[ch] + 16'h1) & mask;
                    set_o = (old_cnt[ch] == mask);
                    set_m = (nxt == m_cmp[i][ch]);
                    m_cnt[i][ch] = (set_m && md[3]) ? 16'h0 : nxt;
                end
                if (data_write && address == 4'h7) begin
                    if (data_in[ch])     m_match[i][ch] = 1'b0;
                    if (data_in[4 + ch]) m_ovf[i][ch]   = 1'b0;
                end
                if (set_m) m_match[i][ch] = 1'b1;
                if (set_o) m_ovf[i][ch]   = 1'b1;
                if (data_write && ch == s) begin
                    if (address == 4'h1) m_mode[i][ch] = data_in[3:0];
                    if (address == 4'h5) m_cmp[i][ch]  = {m_cmp[i][ch][15:8], data_in};
                    if (address == 4'h6 && i == 0) m_cmp[i][ch] = {data_in, m_cmp[i][ch][7:0]};
                end
            end
            if (data_write && address == 4'h0) m_sel[i] = data_in[1:0];
        end
    endtask

    function automatic logic [7:0] m_read(input int i, input logic [3:0] a);
        int s = int'(m_sel[i]);
        case (a)
            4'h0:    return {6'b0, m_sel[i]};
            4'h1:    return {4'b0, m_mode[i][s]};
            4'h2:    return m_snap[i][7:0];
            4'h3:    return (i == 0) ? m_snap[i][15:8] : 8'h00;
            4'h5:    return m_cmp[i][s][7:0];
            4'h6:    return (i == 0) ? m_cmp[i][s][15:8] : 8'h00;
            4'h7:    return {m_ovf[i], m_match[i]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_irq(input int i);
        logic r = 1'b0;
        for (int ch = 0; ch < 4; ch++) r |= m_match[i][ch] & m_mode[i][ch][2];
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && cmp_en) begin
            chk("uo16",   uo16,          {4'h0, m_match[0]});
            chk("uo8",    uo8,           {4'h0, m_match[1]});
            chk("irq16",  {7'b0, irq16}, {7'b0, m_irq(0)});
            chk("irq8",   {7'b0, irq8},  {7'b0, m_irq(1)});
            chk("dout16", do16,          m_read(0, address));
            chk("dout8",  do8,           m_read(1, address));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [7:0] e16, input logic [7:0] e8,
                          input string nm);
        address = a;
        @(negedge clk);
        #1;
        chk({nm, "_w16"}, do16, e16);
        chk({nm, "_w8"},  do8,  e8);
        tick();
    endtask

    task automatic out_chk(input logic [7:0] e_uo, input logic e_irq, input string nm);
        @(negedge clk);
        #1;
        chk({nm, "_uo16"},  uo16, e_uo);
        chk({nm, "_uo8"},   uo8,  e_uo);
        chk({nm, "_irq16"}, {7'b0, irq16}, {7'b0, e_irq});
        chk({nm, "_irq8"},  {7'b0, irq8},  {7'b0, e_irq});
        tick();
    endtask

    task automatic pulse(input logic [7:0] m);
        ui_in = ui_in | m;
        repeat (2) tick();
        ui_in = ui_in & ~m;
        repeat (2) tick();
    endtask

    initial begin
        // Reset with ui_in[0] held high throughout
        ui_in = 8'h01; address = 4'h7;
        #12;
        chk("rst_uo16", uo16, 8'h00);
        chk("rst_irq16", {7'b0, irq16}, 8'h00);
        chk("rst_status16", do16, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        wr(4'h0, 8'h00);
        wr(4'h1, 8'h01);
        repeat (10) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h00, 8'h00, "reset_cnt");
        out_chk(8'h00, 1'b0, "reset_out");

        // Latency on channel 1: raised before edge k, still 0 after k+2, 2nd pulse seen after k+3
        wr(4'h0, 8'h01);
        wr(4'h1, 8'h01);
        ui_in[1] = 1'b1;
        repeat (3) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h00, 8'h00, "lat_k2");
        ui_in[1] = 1'b0;
        repeat (4) tick();
        ui_in[1] = 1'b1;
        repeat (4) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h02, 8'h02, "lat_k3");
        ui_in[1] = 1'b0;
        repeat (2) tick();
        repeat (3) pulse(8'h02);
        repeat (5) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h05, 8'h05, "five_lo");
        rd_chk(4'h3, 8'h00, 8'h00, "five_hi");

        // Both-edges on channel 2, falling on channel 3
        wr(4'h0, 8'h02); wr(4'h1, 8'h03);
        wr(4'h0, 8'h03); wr(4'h1, 8'h02);
        repeat (4) pulse(8'h0C);
        repeat (5) tick();
        wr(4'h0, 8'h02); wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h08, 8'h08, "both_edges");
        wr(4'h0, 8'h03); wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h04, 8'h04, "fall_edges");

        // Compare with auto-reload and interrupt on channel 0
        ui_in[0] = 1'b0;
        repeat (4) tick();
        wr(4'h0, 8'h80);
        wr(4'h5, 8'h03); wr(4'h6, 8'h00); wr(4'h1, 8'h0D);
        repeat (3) pulse(8'h01);
        repeat (4) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h00, 8'h00, "reload_cnt");
        rd_chk(4'h7, 8'h01, 8'h01, "match_status");
        out_chk(8'h01, 1'b1, "match_out");
        wr(4'h7, 8'h01);
        rd_chk(4'h7, 8'h00, 8'h00, "status_clr");
        out_chk(8'h00, 1'b0, "clr_out");

        // Wrap from all-ones
        wr(4'h1, 8'h01);
        wr(4'h2, 8'hFF); wr(4'h3, 8'hFF);
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'hFF, 8'hFF, "wrap_pre_lo");
        rd_chk(4'h3, 8'hFF, 8'h00, "wrap_pre_hi");
        pulse(8'h01);
        repeat (4) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h00, 8'h00, "wrap_lo");
        rd_chk(4'h3, 8'h00, 8'h00, "wrap_hi");
        rd_chk(4'h7, 8'h10, 8'h10, "wrap_ovf");
        wr(4'h7, 8'hFF);

        // Edge lands in the same cycle as a CNT_LO write
        ui_in[0] = 1'b1;
        repeat (3) tick();
        wr(4'h2, 8'h40);
        ui_in[0] = 1'b0;
        repeat (4) tick();
        wr(4'h4, 8'h00);
        rd_chk(4'h2, 8'h40, 8'h40, "coll_cnt");

        // Match set in the same cycle as a STATUS clear
        wr(4'h5, 8'h41); wr(4'h6, 8'h00);
        ui_in[0] = 1'b1;
        repeat (3) tick();
        wr(4'h7, 8'h01);
        ui_in[0] = 1'b0;
        repeat (2) tick();
        rd_chk(4'h7, 8'h01, 8'h01, "coll_flag");
        out_chk(8'h01, 1'b0, "coll_out");
        wr(4'h7, 8'hFF);

        // Randomised traffic, with occasional asynchronous reset pulses mid-cycle
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ui_in[3:0] = ui_in[3:0] ^ (4'($urandom) & 4'($urandom));
            ui_in[7:4] = 4'($urandom);
            if ($urandom_range(0, 99) < 25) begin
                address    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                         : 4'($urandom_range(0, 7));
                data_in    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                data_write = 1'b1;
            end else begin
                data_write = 1'b0;
                address    = 4'($urandom_range(0, 15));
            end
            if (cyc % 1000 == 700) begin
                #1 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            tick();
        end
        data_write = 1'b0;
        repeat (3) tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
